// File: rtl/free_release_dlk.sv
// free_release_dlk: release engine for the allocation-tracking table. Queues free requests, scans the
// table for the freed base address, strobes a clear on the lowest match or flags a double/invalid free.
// Optional statistics (max_scan_o tracking) are built only when DLK_FREE_STATS_EN is defined.
module free_release_dlk #(
  parameter int SIZE       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rst_us,
  input  logic             free_valid_i,
  input  logic [31:0]      free_addr_i,
  output logic             free_ready_o,
  output logic [IDX_W-1:0] tbl_idx_o,
  input  logic [31:0]      tbl_data_i,
  output logic             tbl_clear_o,
  output logic [IDX_W-1:0] tbl_clear_idx_o,
  output logic             busy_o,
  output logic             double_free_o,
  output logic [31:0]      double_free_addr_o,
  output logic [15:0]      free_count_o,
  output logic [IDX_W:0]   max_scan_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCAN_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SCAN     = 2'd1;
  localparam logic [1:0] ST_CLEAR    = 2'd2;
  localparam logic [1:0] ST_NOTFOUND = 2'd3;

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic              srst_s;
  logic              push_s;
  logic              pop_s;
  logic              hit_s;
  logic              miss_s;

  logic [31:0]       fifo_mem_q [FIFO_DEPTH];
  logic [31:0]       fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       cur_addr_q, cur_addr_d;
  logic [IDX_W-1:0]  clear_idx_q, clear_idx_d;
  logic              clear_stb_q, clear_stb_d;
  logic              dbl_q, dbl_d;
  logic [31:0]       dbl_addr_q, dbl_addr_d;
  logic [15:0]       count_q, count_d;

  assign srst_s = ~rst_ni | rst_us;

  // Null frees are acknowledged but never enter the queue.
  assign free_ready_o = (fifo_cnt_q != CNT_FULL);
  assign push_s       = free_valid_i & free_ready_o & (free_addr_i != 32'h0000_0000);
  assign pop_s        = (state_q == ST_IDLE) & (fifo_cnt_q != CNT_ZERO);
  assign hit_s        = (state_q == ST_SCAN) & (tbl_data_i == cur_addr_q);
  assign miss_s       = (state_q == ST_SCAN) & ~hit_s & (idx_q == IDX_LAST);

  // Pending-request queue: write/read pointers and occupancy.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_mem_d[i] = fifo_mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = free_addr_i;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Scan sequencer; idx returns to zero whenever SCAN is left so tbl_idx_o idles at 0.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_addr_d  = cur_addr_q;
    clear_idx_d = clear_idx_q;
    clear_stb_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = IDX_ZERO;
        if (pop_s) begin
          cur_addr_d = fifo_mem_q[rd_ptr_q];
          state_d    = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit_s) begin
          clear_idx_d = idx_q;
          clear_stb_d = 1'b1;
          idx_d       = IDX_ZERO;
          state_d     = ST_CLEAR;
        end else if (miss_s) begin
          idx_d   = IDX_ZERO;
          state_d = ST_NOTFOUND;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_SCAN;
        end
      end
      ST_CLEAR:    state_d = ST_IDLE;
      ST_NOTFOUND: state_d = ST_IDLE;
      default: begin
        idx_d   = IDX_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Release counter (saturating) and sticky first-failure capture.
  always_comb begin
    count_d    = count_q;
    dbl_d      = dbl_q;
    dbl_addr_d = dbl_addr_q;
    if ((state_q == ST_CLEAR) && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'h0001;
    end else begin
      count_d = count_q;
    end
    if ((state_q == ST_NOTFOUND) && !dbl_q) begin
      dbl_d      = 1'b1;
      dbl_addr_d = cur_addr_q;
    end else begin
      dbl_d      = dbl_q;
      dbl_addr_d = dbl_addr_q;
    end
  end

  // Register update; either reset source clears everything and aborts a scan.
  always_ff @(posedge clk_i) begin
    if (srst_s) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 32'h0000_0000;
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      fifo_cnt_q  <= CNT_ZERO;
      state_q     <= ST_IDLE;
      idx_q       <= IDX_ZERO;
      cur_addr_q  <= 32'h0000_0000;
      clear_idx_q <= IDX_ZERO;
      clear_stb_q <= 1'b0;
      dbl_q       <= 1'b0;
      dbl_addr_q  <= 32'h0000_0000;
      count_q     <= 16'h0000;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_addr_q  <= cur_addr_d;
      clear_idx_q <= clear_idx_d;
      clear_stb_q <= clear_stb_d;
      dbl_q       <= dbl_d;
      dbl_addr_q  <= dbl_addr_d;
      count_q     <= count_d;
    end
  end

  assign tbl_idx_o          = idx_q;
  assign tbl_clear_o        = clear_stb_q;
  assign tbl_clear_idx_o    = clear_idx_q;
  assign busy_o             = (state_q != ST_IDLE) | (fifo_cnt_q != CNT_ZERO);
  assign double_free_o      = dbl_q;
  assign double_free_addr_o = dbl_addr_q;
  assign free_count_o       = count_q;

`ifdef DLK_FREE_STATS_EN
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_SIZE = SCAN_W'(SIZE);

  logic [SCAN_W-1:0] scan_len_s;
  logic [SCAN_W-1:0] max_scan_q, max_scan_d;

  // Entries compared by the scan ending this cycle, folded into the running maximum.
  always_comb begin
    if (hit_s) begin
      scan_len_s = {1'b0, idx_q} + SCAN_ONE;
    end else begin
      scan_len_s = SCAN_SIZE;
    end
    if ((hit_s | miss_s) && (scan_len_s > max_scan_q)) begin
      max_scan_d = scan_len_s;
    end else begin
      max_scan_d = max_scan_q;
    end
  end

  // Statistics register, cleared by either reset.
  always_ff @(posedge clk_i) begin
    if (srst_s) begin
      max_scan_q <= {SCAN_W{1'b0}};
    end else begin
      max_scan_q <= max_scan_d;
    end
  end

  assign max_scan_o = max_scan_q;
`else
  assign max_scan_o = {SCAN_W{1'b0}};
`endif

endmodule

// File: tb/tb_free_release_dlk.sv
// Self-checking bench for free_release_dlk: a table model, a strobe monitor and a request-level
// reference model that predicts clear cycles/indices, counters and the double-free capture.
module tb_free_release_dlk;
  localparam int SIZE       = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = $clog2(SIZE);

  logic clk = 1'b0;
  logic rst_ni, rst_us, free_valid_i, free_ready_o, tbl_clear_o, busy_o, double_free_o;
  logic [31:0] free_addr_i, tbl_data_i, double_free_addr_o;
  logic [IDX_W-1:0] tbl_idx_o, tbl_clear_idx_o;
  logic [15:0] free_count_o;
  logic [IDX_W:0] max_scan_o;

  logic [31:0] tbl [SIZE];
  logic host_wr, host_clr_all;
  logic [IDX_W-1:0] host_idx;
  logic [31:0] host_data;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int clr_cyc_q[$];
  int clr_idx_q[$];
  int dbl_rise_q[$];
  logic dbl_prev = 1'b0;

  logic [31:0] mtbl [SIZE];
  logic [31:0] acc_addr[$];
  int acc_t[$];
  int m_count = 0;
  int m_idle_at = 0;
  int m_scan = 0;
  logic m_dbl = 1'b0;
  logic [31:0] m_dbl_addr = 32'h0;

  free_release_dlk #(.SIZE(SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rst_us(rst_us),
    .free_valid_i(free_valid_i), .free_addr_i(free_addr_i), .free_ready_o(free_ready_o),
    .tbl_idx_o(tbl_idx_o), .tbl_data_i(tbl_data_i),
    .tbl_clear_o(tbl_clear_o), .tbl_clear_idx_o(tbl_clear_idx_o),
    .busy_o(busy_o), .double_free_o(double_free_o), .double_free_addr_o(double_free_addr_o),
    .free_count_o(free_count_o), .max_scan_o(max_scan_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tracking table: host writes, and zeroing on the clear strobe.
  assign tbl_data_i = tbl[tbl_idx_o];
  always @(posedge clk) begin
    if (host_clr_all) for (int i = 0; i < SIZE; i++) tbl[i] <= 32'h0;
    else if (host_wr) tbl[host_idx] <= host_data;
    if (tbl_clear_o === 1'b1) tbl[tbl_clear_idx_o] <= 32'h0;
  end

  // Monitor: events tagged with the cycle number ending at the next rising edge.
  always @(negedge clk) begin
    if (tbl_clear_o === 1'b1) begin
      clr_cyc_q.push_back(cyc + 1);
      clr_idx_q.push_back(int'(tbl_clear_idx_o));
    end
    if (double_free_o === 1'b1 && !dbl_prev) dbl_rise_q.push_back(cyc + 1);
    dbl_prev = (double_free_o === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tbl_write(input int i, input logic [31:0] d);
    host_wr = 1'b1; host_idx = i[IDX_W-1:0]; host_data = d; mtbl[i] = d;
    step(1);
    host_wr = 1'b0;
  endtask

  task automatic clear_table();
    host_clr_all = 1'b1;
    for (int i = 0; i < SIZE; i++) mtbl[i] = 32'h0;
    step(1);
    host_clr_all = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, output int t, output int w);
    w = 0;
    free_valid_i = 1'b1; free_addr_i = a;
    while (free_ready_o !== 1'b1 && w < 300) begin step(1); w++; end
    if (w >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", free_ready_o, w);
    end
    @(posedge clk); #1; t = cyc;
    free_valid_i = 1'b0; free_addr_i = 32'h0;
    if (a != 32'h0) begin acc_addr.push_back(a); acc_t.push_back(t); end
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy_o !== 1'b0 && g < 3000) begin step(1); g++; end
    if (busy_o !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_drain: busy=%b after %0d cycles, required 0", tag, busy_o, g);
    end
    step(2);
  endtask

  // Request-level model: serial processing, lowest-index match, cycle arithmetic from the latency rules.
  task automatic model_check(input string tag, input int base);
    int exp_cyc[$]; int exp_idx[$];
    bit new_dbl = 1'b0;
    int dbl_cyc = 0;
    logic [31:0] a; int t, p, k, n_got, ms;
    while (acc_addr.size() > 0) begin
      a = acc_addr.pop_front(); t = acc_t.pop_front();
      p = (t + 1 > m_idle_at) ? t + 1 : m_idle_at;
      k = -1;
      for (int i = 0; i < SIZE; i++) if (k < 0 && mtbl[i] == a) k = i;
      if (k >= 0) begin
        exp_cyc.push_back(p + 2 + k); exp_idx.push_back(k);
        mtbl[k] = 32'h0;
        if (m_count < 65535) m_count++;
        m_idle_at = p + 3 + k;
        if (k + 1 > m_scan) m_scan = k + 1;
      end else begin
        if (!m_dbl) begin m_dbl = 1'b1; m_dbl_addr = a; new_dbl = 1'b1; dbl_cyc = p + 2 + SIZE; end
        m_idle_at = p + 2 + SIZE;
        m_scan = SIZE;
      end
    end
    n_got = clr_cyc_q.size() - base;
    n_checks++;
    if (n_got != exp_cyc.size()) begin
      n_fail++; $display("FAIL %s_nclears: got %0d, required %0d", tag, n_got, exp_cyc.size());
    end
    for (int i = 0; i < exp_cyc.size() && i < n_got; i++) begin
      n_checks++;
      if (clr_cyc_q[base+i] != exp_cyc[i] || clr_idx_q[base+i] != exp_idx[i]) begin
        n_fail++;
        $display("FAIL %s_clear%0d: got cyc %0d idx %0d, required cyc %0d idx %0d", tag, i,
                 clr_cyc_q[base+i], clr_idx_q[base+i], exp_cyc[i], exp_idx[i]);
      end
    end
    n_checks++;
    if (free_count_o !== m_count[15:0]) begin
      n_fail++; $display("FAIL %s_count: got %0d, required %0d", tag, free_count_o, m_count);
    end
    n_checks++;
    if (double_free_o !== m_dbl || double_free_addr_o !== m_dbl_addr) begin
      n_fail++;
      $display("FAIL %s_dbl: got %b/%h, required %b/%h", tag, double_free_o, double_free_addr_o, m_dbl, m_dbl_addr);
    end
    if (new_dbl) begin
      n_checks++;
      if (dbl_rise_q.size() == 0 || dbl_rise_q[$] != dbl_cyc) begin
        n_fail++;
        $display("FAIL %s_dbl_cycle: got %0d, required %0d", tag,
                 (dbl_rise_q.size() == 0) ? -1 : dbl_rise_q[$], dbl_cyc);
      end
    end
`ifdef DLK_FREE_STATS_EN
    ms = m_scan;
`else
    ms = 0;
`endif
    n_checks++;
    if (int'(max_scan_o) != ms) begin
      n_fail++; $display("FAIL %s_max_scan: got %0d, required %0d", tag, max_scan_o, ms);
    end
  endtask

  task automatic check_cleared(input string tag);
    n_checks++;
    if ({tbl_clear_o, busy_o, double_free_o, free_ready_o} !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s_flags: got clr/busy/dbl/rdy=%b%b%b%b, required 0001", tag,
               tbl_clear_o, busy_o, double_free_o, free_ready_o);
    end
    n_checks++;
    if (tbl_idx_o !== '0 || tbl_clear_idx_o !== '0) begin
      n_fail++; $display("FAIL %s_idx: got %0d/%0d, required 0/0", tag, tbl_idx_o, tbl_clear_idx_o);
    end
    n_checks++;
    if (free_count_o !== 16'h0 || double_free_addr_o !== 32'h0 || max_scan_o !== '0) begin
      n_fail++;
      $display("FAIL %s_counters: got cnt %0d addr %h max %0d, required 0", tag,
               free_count_o, double_free_addr_o, max_scan_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; rst_us = 1'b0; free_valid_i = 1'b0; free_addr_i = 32'h0;
    host_wr = 1'b0; host_clr_all = 1'b1; host_idx = '0; host_data = 32'h0;
    for (int i = 0; i < SIZE; i++) mtbl[i] = 32'h0;
    step(3);
    host_clr_all = 1'b0;
    rst_ni = 1'b1;
    check_cleared("reset");
    step(1);
    check_cleared("reset_hold");
  endtask

  task automatic test_single_match();
    int t, w, base;
    tbl_write(5, 32'h8000_0100);
    base = clr_cyc_q.size();
    send(32'h8000_0100, t, w);
    wait_idle("single");
    n_checks++;
    if (clr_cyc_q.size() <= base || clr_cyc_q[base] != t + 8 || clr_idx_q[base] != 5) begin
      n_fail++;
      $display("FAIL single_t8: got %0d events, first cyc %0d, required cyc %0d idx 5",
               clr_cyc_q.size() - base, (clr_cyc_q.size() > base) ? clr_cyc_q[base] - t : -1, 8);
    end
    model_check("single", base);
  endtask

  task automatic test_miss();
    int t, w, base;
    base = clr_cyc_q.size();
    send(32'h8000_0200, t, w);
    wait_idle("miss1");
    n_checks++;
    if (dbl_rise_q.size() == 0 || dbl_rise_q[$] != t + 3 + SIZE) begin
      n_fail++; $display("FAIL miss_dbl_cycle: got rise count %0d, required rise at t+%0d", dbl_rise_q.size(), 3 + SIZE);
    end
    model_check("miss1", base);
    base = clr_cyc_q.size();
    send(32'h8000_0300, t, w);
    wait_idle("miss2");
    model_check("miss2", base);
  endtask

  task automatic test_null_free();
    int t, w, base;
    bit busy_seen = 1'b0;
    base = clr_cyc_q.size();
    send(32'h0, t, w);
    n_checks++;
    if (w != 0) begin n_fail++; $display("FAIL null_accept: waited %0d cycles, required 0", w); end
    for (int i = 0; i < 8; i++) begin
      if (busy_o !== 1'b0) busy_seen = 1'b1;
      step(1);
    end
    n_checks++;
    if (busy_seen) begin n_fail++; $display("FAIL null_busy: got busy 1, required 0"); end
    model_check("null", base);
  endtask

  task automatic test_duplicate();
    int t, w, base;
    clear_table();
    tbl_write(3, 32'h0000_0040);
    tbl_write(9, 32'h0000_0040);
    base = clr_cyc_q.size();
    send(32'h0000_0040, t, w);
    wait_idle("dup");
    n_checks++;
    if (clr_cyc_q.size() - base != 1 || clr_idx_q[$] != 3) begin
      n_fail++; $display("FAIL dup_lowest: got %0d strobes last idx %0d, required 1 at idx 3",
                         clr_cyc_q.size() - base, clr_idx_q[$]);
    end
    model_check("dup", base);
  endtask

  task automatic test_back_to_back();
    int t, w, base;
    int idxs[5] = '{2, 7, 0, 15, 31};
    logic [31:0] vals[5];
    clear_table();
    for (int i = 0; i < 5; i++) begin
      vals[i] = 32'h1000_0000 | ($urandom & 32'h00FF_FF00) | (i + 1);
      tbl_write(idxs[i], vals[i]);
    end
    base = clr_cyc_q.size();
    for (int i = 0; i < 5; i++) send(vals[i], t, w);
    n_checks++;
    if (free_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got ready %b, required 0", free_ready_o); end
    wait_idle("b2b");
    model_check("b2b", base);
  endtask

  task automatic test_soft_reset();
    int t, w, base, g;
    clear_table();
    tbl_write(20, 32'hA5A5_0020);
    tbl_write(25, 32'hA5A5_0025);
    tbl_write(26, 32'hA5A5_0026);
    base = clr_cyc_q.size();
    send(32'hA5A5_0020, t, w);
    send(32'hA5A5_0025, t, w);
    send(32'hA5A5_0026, t, w);
    g = 0;
    while (tbl_idx_o !== 5'd10 && g < 100) begin step(1); g++; end
    n_checks++;
    if (tbl_idx_o !== 5'd10) begin n_fail++; $display("FAIL srst_reach_idx10: got %0d, required 10", tbl_idx_o); end
    rst_us = 1'b1;
    step(1);
    rst_us = 1'b0;
    acc_addr.delete(); acc_t.delete();
    m_count = 0; m_dbl = 1'b0; m_dbl_addr = 32'h0; m_scan = 0; m_idle_at = 0;
    check_cleared("srst");
    step(40);
    n_checks++;
    if (clr_cyc_q.size() != base || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL srst_abort: got %0d strobes busy %b, required 0 strobes busy 0",
                         clr_cyc_q.size() - base, busy_o);
    end
    send(32'hA5A5_0020, t, w);
    wait_idle("srst_next");
    model_check("srst_next", base);
  endtask

  task automatic test_random();
    int t, w, base, j;
    logic [31:0] a;
    clear_table();
    for (int i = 0; i < SIZE; i++) tbl_write(i, $urandom | 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      j = $urandom_range(0, SIZE - 1);
      tbl_write($urandom_range(0, SIZE - 1), mtbl[j]);
    end
    base = clr_cyc_q.size();
    for (int n = 0; n < 20; n++) begin
      j = $urandom_range(0, 9);
      if (j < 6) begin
        a = mtbl[$urandom_range(0, SIZE - 1)];
        if (a == 32'h0) a = $urandom | 32'h0000_0001;
      end else if (j == 6) a = 32'h0;
      else a = $urandom | 32'h0000_0001;
      send(a, t, w);
      step($urandom_range(0, 3));
    end
    wait_idle("rand");
    model_check("rand", base);
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_miss();
    test_null_free();
    test_duplicate();
    test_back_to_back();
    test_soft_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/free_release_dlk.md
Name: free_release_dlk

Overview:
- Release engine for the allocation-tracking table, which stores base addresses of live data blocks.
- The allocation side inserts base addresses. This block handles the opposite direction: it consumes free requests, scans the table through a read port, and issues a one-cycle clear strobe for the matching entry.
- A request whose address is not in the table is flagged as a double/invalid free.
- It sits between the core's free-event source and the tracking table.

Parameters:
- SIZE, 32: number of table entries scanned (power of two, at least 2).
- FIFO_DEPTH, 4: pending free-request queue depth (power of two, at least 2).
- IDX_W, $clog2(SIZE): derived index width; do not override.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- rst_us  in  1  custom synchronous clear, active-high, same effect as rst_ni.
- free_valid_i  in  1  free request valid.
- free_addr_i  in  32  base address being freed.
- free_ready_o  out  1  request accepted when valid and ready are both high.
- tbl_idx_o  out  IDX_W  table index currently read.
- tbl_data_i  in  32  table entry at tbl_idx_o; combinational, same cycle.
- tbl_clear_o  out  1  one-cycle strobe; the table zeroes the entry at tbl_clear_idx_o.
- tbl_clear_idx_o  out  IDX_W  index to clear; valid while tbl_clear_o is high.
- busy_o  out  1  FSM not in IDLE, or FIFO not empty.
- double_free_o  out  1  sticky error flag.
- double_free_addr_o  out  32  address of the first failing free.
- free_count_o  out  16  successful releases, saturating at 0xFFFF.
- max_scan_o  out  IDX_W+1  statistics port (see Optional Feature).

Behaviour:
- Reset (rst_ni low or rst_us high at a clock edge):
  - FIFO emptied, FSM to IDLE.
  - All outputs 0, except free_ready_o = 1 after reset deasserts.
  - Counters and sticky flags cleared.
  - An in-progress scan is aborted with no clear strobe.
  - rst_us takes priority over every other event in the same cycle.
- Handshake:
  - free_ready_o = !fifo_full, with no bypass.
  - A request accepted while full is impossible; a push and pop in the same cycle are both honoured.
  - free_addr_i == 0 (null free) is accepted but not enqueued, and has no other effect.
- FSM states: IDLE, SCAN, CLEAR, NOTFOUND.
  - IDLE: if the FIFO is non-empty, pop the head into cur_addr, set idx = 0, go to SCAN.
  - SCAN: tbl_idx_o = idx. The compare is on the full 32 bits of tbl_data_i against cur_addr.
    - On match: latch clear_idx = idx, go to CLEAR.
    - Else if idx == SIZE-1: go to NOTFOUND.
    - Else idx += 1.
  - CLEAR: tbl_clear_o = 1 for exactly this cycle; free_count_o increments (saturating); go to IDLE.
  - NOTFOUND: if double_free_o is 0, set it and capture cur_addr into double_free_addr_o; later failures do not overwrite it. Go to IDLE.
- Matching:
  - The lowest matching index wins.
  - Table contents may change mid-scan; each compare uses the current-cycle data.
- Latency (request accepted at edge t):
  - Pop occurs in cycle t+1.
  - Index 0 is compared in cycle t+2.
  - A match at index k gives tbl_clear_o in cycle t+3+k.
  - A full miss gives double_free_o visible from cycle t+3+SIZE.
- Throughput: one request per (k+3) cycles; back-to-back requests queue in the FIFO.
- tbl_idx_o holds 0 outside SCAN. tbl_clear_idx_o holds its last value outside CLEAR.
- Width rules: idx has IDX_W bits and never wraps inside SCAN. free_count_o saturates rather than wrapping.

Optional Feature:
- Macro: DLK_FREE_STATS_EN.
- Defined: max_scan_o tracks the maximum number of entries compared in any completed scan (k+1 on a match, SIZE on a miss). It updates on entry to CLEAR or NOTFOUND, and is cleared by either reset.
- Undefined: max_scan_o is tied to 0 and no tracking logic is built. All other behaviour is identical.

Test Plan:
- Table has entry 5 = 0x8000_0100; free 0x8000_0100 accepted at edge t -> tbl_clear_o high in exactly cycle t+8 with tbl_clear_idx_o = 5; free_count_o = 1; double_free_o stays 0.
- Free 0x8000_0200, not in the table -> no tbl_clear_o; double_free_o = 1 and double_free_addr_o = 0x8000_0200 from cycle t+3+SIZE. A second miss on 0x8000_0300 leaves the captured address at 0x8000_0200.
- Five back-to-back valid frees with FIFO_DEPTH=4 -> free_ready_o drops when the FIFO is full. All five are eventually cleared in acceptance order, and free_count_o = 5.
- Free 0x0 -> accepted in one cycle; busy_o stays 0; no scan, no clear strobe, no count change.
- Duplicate 0x40 at entries 3 and 9 -> single clear strobe at index 3.
- rst_us pulsed during SCAN at idx 10 with 2 requests queued -> no clear strobe; FIFO empty; free_count_o, double_free_o and max_scan_o (when the macro is defined) all 0. The next free completes normally.
